// File: rtl/list_map_engine.sv
// List map engine: loads a list tail-first onto a stack, then pops each element through a
// fixed-latency function and writes the results head-first with write backpressure.
module list_map_engine #(
    parameter int W      = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH) + 1,
    parameter int FN_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          start_ready,
    input  logic [AW-1:0] len,
    input  logic [1:0]    op,
    input  logic [W-1:0]  operand,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] result_len
);

    localparam int SW  = $clog2(DEPTH);
    localparam int SHW = $clog2(W);
    localparam int FCW = $clog2(FN_LAT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, POP, FUNC, WRITE, DONE} state_t;

    state_t          state;
    logic [W-1:0]    stack [DEPTH];
    logic [AW-1:0]   sp;
    logic [AW-1:0]   len_q;
    logic [AW-1:0]   rd_cnt;
    logic [AW-1:0]   widx;
    logic [1:0]      op_q;
    logic [W-1:0]    operand_q;
    logic            rd_vld;
    logic [FCW-1:0]  fcnt;
    logic [W-1:0]    top;
    logic [W-1:0]    fx;
    logic [W-1:0]    fx_q;

    always_comb begin
        top = stack[SW'(sp - AW'(1))];
        case (op_q)
            2'd0:    fx = top + operand_q;
            2'd1:    fx = top - operand_q;
            2'd2:    fx = top << operand_q[SHW-1:0];
            default: fx = top;
        endcase
    end

    // Stack storage carries no reset; only the pointer defines valid contents.
    always_ff @(posedge clk) begin
        if (state == LOAD && rd_vld)
            stack[SW'(sp)] <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sp          <= '0;
            len_q       <= '0;
            rd_cnt      <= '0;
            widx        <= '0;
            op_q        <= '0;
            operand_q   <= '0;
            rd_vld      <= 1'b0;
            fcnt        <= '0;
            fx_q        <= '0;
            start_ready <= 1'b1;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            result_len  <= '0;
        end else begin
            rd_vld <= rd_en;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    len_q       <= len;
                    op_q        <= op;
                    operand_q   <= operand;
                    sp          <= '0;
                    widx        <= '0;
                    error       <= 1'b0;
                    result_len  <= '0;
                    start_ready <= 1'b0;
                    if (len == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (len > AW'(DEPTH)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end else begin
                        state   <= LOAD;
                        rd_en   <= 1'b1;
                        rd_addr <= len - AW'(1);
                        rd_cnt  <= AW'(1);
                    end
                end
                LOAD: begin
                    // Reads run one cycle ahead of pushes; the final push has no read beside it.
                    rd_en <= (rd_cnt < len_q);
                    if (rd_cnt < len_q) begin
                        rd_addr <= len_q - AW'(1) - rd_cnt;
                        rd_cnt  <= rd_cnt + AW'(1);
                    end
                    if (rd_vld)
                        sp <= sp + AW'(1);
                    if (rd_vld && !rd_en)
                        state <= POP;
                end
                POP: begin
                    fx_q  <= fx;
                    sp    <= sp - AW'(1);
                    fcnt  <= '0;
                    state <= FUNC;
                end
                FUNC: begin
                    if (fcnt == FCW'(FN_LAT - 1)) begin
                        state    <= WRITE;
                        wr_valid <= 1'b1;
                        wr_addr  <= widx;
                        wr_data  <= fx_q;
                    end else begin
                        fcnt <= fcnt + FCW'(1);
                    end
                end
                WRITE: if (wr_ready) begin
                    wr_valid <= 1'b0;
                    widx     <= widx + AW'(1);
                    if (sp == '0) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        result_len <= widx + AW'(1);
                    end else begin
                        state <= POP;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_list_map_engine.sv
// Directed bench for list_map_engine: list memory model, write capture and per-scenario checks.
module tb_list_map_engine;

    localparam int W      = 32;
    localparam int DEPTH  = 16;
    localparam int AW     = 5;
    localparam int FN_LAT = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          start_ready;
    logic [AW-1:0] len;
    logic [1:0]    op;
    logic [W-1:0]  operand;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          done;
    logic          error;
    logic [AW-1:0] result_len;

    logic [W-1:0]  mem [32];
    logic [W-1:0]  wdata [64];
    logic [AW-1:0] waddr [64];
    logic [AW-1:0] raddr [64];
    int            wcount;
    int            rcount;
    int            checks;
    int            errors;

    list_map_engine #(.W(W), .DEPTH(DEPTH), .AW(AW), .FN_LAT(FN_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
        .len(len), .op(op), .operand(operand),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .error(error), .result_len(result_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // List memory (one-cycle read latency) and write/read capture.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            if (rcount < 64) begin
                raddr[rcount] = rd_addr;
                rcount++;
            end
        end
        if (wr_valid && wr_ready && wcount < 64) begin
            waddr[wcount] = wr_addr;
            wdata[wcount] = wr_data;
            wcount++;
        end
    end

    task automatic run_job(input logic [AW-1:0] l, input logic [1:0] o, input logic [W-1:0] opnd,
                           input int stall_addr, input logic [W-1:0] stall_data, output int cyc);
        bit stalled;
        stalled = 0;
        wcount  = 0;
        rcount  = 0;
        cyc     = 0;
        @(negedge clk);
        start = 1'b1; len = l; op = o; operand = opnd;
        @(posedge clk);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (stall_addr >= 0 && !stalled && wr_valid && wr_addr == AW'(stall_addr)) begin
                wr_ready = 1'b0;
                stalled  = 1;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if (wr_valid !== 1'b1 || wr_addr !== AW'(stall_addr) || wr_data !== stall_data) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                                 s, wr_valid, wr_addr, wr_data, stall_addr, stall_data);
                    end
                end
                wr_ready = 1'b1;
            end
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within 2000 cycles, required done=1");
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1; len = '0; op = '0; operand = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({start_ready, rd_en, wr_valid, done, error} !== 5'b10000 || result_len !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy/rd/wv/done/err=%b result_len=%0d, required 10000 and 0",
                     {start_ready, rd_en, wr_valid, done, error}, result_len);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int cyc;
        for (int i = 0; i < 6; i++) mem[i] = i;
        run_job(5'd6, 2'd0, 32'd1, -1, '0, cyc);
        checks++;
        if (cyc !== 44) begin errors++; $display("FAIL add_latency: got %0d cycles, required 44", cyc); end
        checks++;
        if (result_len !== 5'd6 || error !== 1'b0) begin
            errors++; $display("FAIL add_result_len: len=%0d err=%b, required 6 and 0", result_len, error);
        end
        checks++;
        if (wcount !== 6 || rcount !== 6) begin
            errors++; $display("FAIL add_counts: writes=%0d reads=%0d, required 6 and 6", wcount, rcount);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (waddr[i] !== AW'(i) || wdata[i] !== W'(i + 1)) begin
                errors++; $display("FAIL add_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                                   i, waddr[i], wdata[i], i, i + 1);
            end
            checks++;
            if (raddr[i] !== AW'(5 - i)) begin
                errors++; $display("FAIL add_read_order[%0d]: addr=%0d, required %0d", i, raddr[i], 5 - i);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL add_done_pulse: done=%b rdy=%b, required 0 and 1", done, start_ready);
        end
    endtask

    task automatic test_len_zero();
        int cyc;
        run_job(5'd0, 2'd0, 32'd7, -1, '0, cyc);
        checks++;
        if (cyc !== 1 || result_len !== '0 || error !== 1'b0 || wcount !== 0 || rcount !== 0) begin
            errors++; $display("FAIL len_zero: cyc=%0d len=%0d err=%b w=%0d r=%0d, required 1 0 0 0 0",
                               cyc, result_len, error, wcount, rcount);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow_and_full();
        int cyc;
        run_job(5'd17, 2'd3, 32'd0, -1, '0, cyc);
        checks++;
        if (cyc !== 1 || error !== 1'b1 || rcount !== 0 || wcount !== 0) begin
            errors++; $display("FAIL overflow: cyc=%0d err=%b r=%0d w=%0d, required 1 1 0 0",
                               cyc, error, rcount, wcount);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL overflow_hold: err=%b done=%b, required 1 and 0", error, done);
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 + 32'(i * 3);
        run_job(5'd16, 2'd3, 32'd0, -1, '0, cyc);
        checks++;
        if (cyc !== 114 || error !== 1'b0 || result_len !== 5'd16 || wcount !== 16) begin
            errors++; $display("FAIL full_depth: cyc=%0d err=%b len=%0d w=%0d, required 114 0 16 16",
                               cyc, error, result_len, wcount);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (waddr[i] !== AW'(i) || wdata[i] !== 32'hA500_0000 + 32'(i * 3)) begin
                errors++; $display("FAIL full_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                                   i, waddr[i], wdata[i], i, 32'hA500_0000 + 32'(i * 3));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cyc;
        for (int i = 0; i < 5; i++) mem[i] = 32'(100 + i * 7);
        run_job(5'd5, 2'd0, 32'd10, 2, 32'd124, cyc);
        checks++;
        if (cyc !== 42 || wcount !== 5 || result_len !== 5'd5) begin
            errors++; $display("FAIL bp_summary: cyc=%0d w=%0d len=%0d, required 42 5 5", cyc, wcount, result_len);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (waddr[i] !== AW'(i) || wdata[i] !== 32'(110 + i * 7)) begin
                errors++; $display("FAIL bp_write[%0d]: addr=%0d data=%0d, required addr=%0d data=%0d",
                                   i, waddr[i], wdata[i], i, 110 + i * 7);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sub_shl();
        int cyc;
        mem[0] = 32'd0;
        run_job(5'd1, 2'd1, 32'd1, -1, '0, cyc);
        checks++;
        if (cyc !== 9 || wcount !== 1 || wdata[0] !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sub_wrap: cyc=%0d w=%0d data=%h, required 9 1 ffffffff", cyc, wcount, wdata[0]);
        end
        @(negedge clk);
        mem[0] = 32'h8000_0001;
        mem[1] = 32'h0000_0003;
        run_job(5'd2, 2'd2, 32'd33, -1, '0, cyc);
        checks++;
        if (wcount !== 2 || wdata[0] !== 32'h0000_0002 || wdata[1] !== 32'h0000_0006) begin
            errors++; $display("FAIL shl_mod: w=%0d data0=%h data1=%h, required 2 00000002 00000006",
                               wcount, wdata[0], wdata[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_func();
        int cyc;
        wcount = 0;
        @(negedge clk);
        start = 1'b1; len = 5'd4; op = 2'd0; operand = 32'd5;
        @(posedge clk);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({start_ready, rd_en, wr_valid, done, error} !== 5'b10000 || result_len !== '0) begin
            errors++; $display("FAIL mid_reset_state: rdy/rd/wv/done/err=%b result_len=%0d, required 10000 and 0",
                               {start_ready, rd_en, wr_valid, done, error}, result_len);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wcount !== 0 || wr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_drop: writes=%0d wv=%b, required 0 and 0", wcount, wr_valid);
        end
        mem[0] = 32'h10; mem[1] = 32'h20; mem[2] = 32'h30;
        run_job(5'd3, 2'd0, 32'h100, -1, '0, cyc);
        checks++;
        if (cyc !== 23 || wcount !== 3 || result_len !== 5'd3) begin
            errors++; $display("FAIL post_reset_job: cyc=%0d w=%0d len=%0d, required 23 3 3", cyc, wcount, result_len);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (waddr[i] !== AW'(i) || wdata[i] !== 32'(32'h110 + i * 16)) begin
                errors++; $display("FAIL post_reset_write[%0d]: addr=%0d data=%h, required addr=%0d data=%h",
                                   i, waddr[i], wdata[i], i, 32'h110 + i * 16);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wcount = 0;
        rcount = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        test_reset();
        test_add();
        test_len_zero();
        test_overflow_and_full();
        test_backpressure();
        test_sub_shl();
        test_reset_mid_func();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
